seg7_pwm_driver: RTL and testbench
==================================

SEG7_PWM_DRIVER -- requirements
Module: seg7_pwm_driver

Interface
REQ-001 SHALL have parameter PRESCALE, default 50000, meaning clk cycles per blink tick (1 kHz at 50 MHz); legal range 2..65535.
REQ-002 SHALL have port clk, input, 1, meaning single system clock; all state is on its rising edge.
REQ-003 SHALL have port reset, input, 1, meaning asynchronous, active-high reset.
REQ-004 SHALL have port address, input, 2, meaning Avalon-MM slave word address.
REQ-005 SHALL have port chipselect, input, 1, meaning Avalon-MM select.
REQ-006 SHALL have port write_n, input, 1, meaning Avalon-MM write strobe, active-low.
REQ-007 SHALL have port writedata, input, 32, meaning Avalon-MM write data.
REQ-008 SHALL have port readdata, output, 32, meaning Avalon-MM read data; combinational, zero wait states.
REQ-009 SHALL have port seg_in, input, 7, meaning active-high segment pattern from the upstream seven-segment PIO out_port; bit0 = segment a.
REQ-010 SHALL have port hex_n, output, 7, meaning registered pin drive to one HEX digit.

Function
REQ-011 SHALL decode writes on chipselect && !write_n: address 0 is CTRL (bit0 enable, bit1 blink_en, bit2 active_low), 1 is BRIGHT[3:0], 2 is BLINK_DIV[15:0], 3 is read-only.
REQ-012 SHALL return registers zero-extended on readdata; address 3 returns {23'b0, blink_phase, 1'b0, seg_lat[6:0]}.
REQ-013 SHALL run a 4-bit pwm_cnt counting 0..14 and wrapping to 0, giving a period of 15 cycles.
REQ-014 SHALL, in the cycle where pwm_cnt==14 (the period boundary), load seg_lat<=seg_in and bright_act<=BRIGHT; BRIGHT writes thus never change duty mid-period.
REQ-015 SHALL define lit = enable && blink_vis && (pwm_cnt < bright_act); bright_act 0 gives always dark, 15 gives always lit.
REQ-016 SHALL run a 16-bit prescaler counting 0..PRESCALE-1 and pulse tick for one cycle at wrap.
REQ-017 SHALL count tick pulses in blink_cnt; when blink_cnt==BLINK_DIV-1 on a tick, it SHALL toggle blink_phase and clear blink_cnt.
REQ-018 SHALL set blink_vis = !blink_en || blink_phase.
REQ-019 SHALL hold blink_phase=1 and blink_cnt=0 when BLINK_DIV==0.
REQ-020 SHALL clear blink_cnt and set blink_phase=1 on any write to BLINK_DIV; a simultaneous tick SHALL lose to the write.
REQ-021 SHALL hold pwm_cnt, prescaler, and blink_cnt at 0 and blink_phase at 1 while enable=0, so that re-enable starts a fresh period.
REQ-022 SHALL register hex_n <= (seg_lat & {7{lit}}) XOR {7{active_low}}, giving a latency of 1 clk from the seg_lat/pwm_cnt state to the pin.
REQ-023 SHALL make a change in seg_in visible on hex_n 1 clk after the next period boundary, i.e. in 2..16 clks.

Reset
REQ-024 SHALL, while reset is high, asynchronously set CTRL=3'b101, BRIGHT=15, BLINK_DIV=0, seg_lat=0, bright_act=15, all counters=0, blink_phase=1, and hex_n=7'h7F (blank, active-low).
REQ-025 SHALL, when reset asserts mid-period, blank hex_n immediately and discard the in-flight period with no partial state retained.
REQ-026 SHALL, on the first clk after reset release, set pwm_cnt=0 and continue from reset values.

Structure
REQ-027 SHALL take from shared package seg7_pkg the register address constants, the CTRL bit indices, PWM_MAX=14, and the reset values.
REQ-028 SHALL put the prescaler, blink counter, and phase in one sub-module, seg7_blink_timer; the register file, PWM, and output stage stay in the top level.

Verification
REQ-029 SHALL cover reset: after release with seg_in=7'h3F and defaults, hex_n=7'h40 from period boundary +1 onward, constant every cycle.
REQ-030 SHALL cover duty: write BRIGHT=5 with seg_in=7'h06; after the next boundary, hex_n=7'h79 for exactly 5 of every 15 clks and 7'h7F for 10.
REQ-031 SHALL cover extremes: BRIGHT=0 gives hex_n stuck at 7'h7F; BRIGHT=15 gives it stuck at the inverted pattern; changing BRIGHT mid-period gives no duty change until the boundary.
REQ-032 SHALL cover blink: PRESCALE=4, BLINK_DIV=3, blink_en=1 makes blink_phase toggle every 12 clks; an off phase is fully blank; a BLINK_DIV rewrite restarts the phase at 1.
REQ-033 SHALL cover polarity and disable: CTRL=3'b001 makes hex_n active-high (a lit segment reads 1); CTRL=0 gives hex_n=7'h00 with counters frozen at 0; readdata at address 3 equals {phase, seg_lat}.
REQ-034 SHALL cover reset mid-operation: asserting reset when pwm_cnt=7 and blink_phase=0 blanks hex_n combinationally; after release all registers read back their reset values.

Source files
------------

// File: rtl/seg7_pkg.sv
// Shared constants for the seven-segment PWM driver: register map, CTRL bit
// positions, PWM period end and reset values.
package seg7_pkg;

    localparam logic [1:0] ADDR_CTRL   = 2'd0;
    localparam logic [1:0] ADDR_BRIGHT = 2'd1;
    localparam logic [1:0] ADDR_DIV    = 2'd2;
    localparam logic [1:0] ADDR_STATUS = 2'd3;

    localparam int CTRL_EN    = 0;
    localparam int CTRL_BLINK = 1;
    localparam int CTRL_ALOW  = 2;

    localparam logic [3:0] PWM_MAX = 4'd14;

    localparam logic [2:0]  CTRL_RST   = 3'b101;
    localparam logic [3:0]  BRIGHT_RST = 4'd15;
    localparam logic [15:0] DIV_RST    = 16'd0;
    localparam logic [6:0]  SEG_RST    = 7'h00;
    localparam logic [6:0]  HEX_RST    = 7'h7F;

endpackage

// File: rtl/seg7_blink_timer.sv
// Blink timebase: prescaler producing a tick every PRESCALE clocks, and a tick
// counter that flips the blink phase every BLINK_DIV ticks.
module seg7_blink_timer #(
    parameter int PRESCALE = 50000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        enable_i,
    input  logic [15:0] blink_div_i,
    input  logic        div_wr_i,
    output logic        blink_phase_o
);

    localparam logic [15:0] PRE_LAST = 16'(PRESCALE - 1);

    logic [15:0] presc_q, presc_d;
    logic [15:0] cnt_q, cnt_d;
    logic        phase_q, phase_d;
    logic        tick;

    always_comb begin
        presc_d = presc_q;
        cnt_d   = cnt_q;
        phase_d = phase_q;
        tick    = 1'b0;
        if (!enable_i) begin
            presc_d = 16'd0;
            cnt_d   = 16'd0;
            phase_d = 1'b1;
        end else begin
            tick    = (presc_q == PRE_LAST);
            presc_d = tick ? 16'd0 : presc_q + 16'd1;
            // A divider rewrite restarts the phase even if a tick lands in the same cycle.
            if (div_wr_i || blink_div_i == 16'd0) begin
                cnt_d   = 16'd0;
                phase_d = 1'b1;
            end else if (tick) begin
                if (cnt_q == blink_div_i - 16'd1) begin
                    cnt_d   = 16'd0;
                    phase_d = !phase_q;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            presc_q <= 16'd0;
            cnt_q   <= 16'd0;
            phase_q <= 1'b1;
        end else begin
            presc_q <= presc_d;
            cnt_q   <= cnt_d;
            phase_q <= phase_d;
        end
    end

    assign blink_phase_o = phase_q;

endmodule

// File: rtl/seg7_pwm_driver.sv
// Avalon-MM controlled brightness/blink driver for one seven-segment digit:
// register file, 15-step PWM and registered active-low/high pin stage.
module seg7_pwm_driver #(
    parameter int PRESCALE = 50000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [1:0]  address,
    input  logic        chipselect,
    input  logic        write_n,
    input  logic [31:0] writedata,
    output logic [31:0] readdata,
    input  logic [6:0]  seg_in,
    output logic [6:0]  hex_n
);

    import seg7_pkg::*;

    logic [2:0]  ctrl_q, ctrl_d;
    logic [3:0]  bright_q, bright_d;
    logic [15:0] div_q, div_d;
    logic [3:0]  pwm_cnt_q, pwm_cnt_d;
    logic [6:0]  seg_lat_q, seg_lat_d;
    logic [3:0]  bright_act_q, bright_act_d;
    logic [6:0]  hex_q, hex_d;

    logic wr_en, div_wr, enable, blink_en, active_low, boundary;
    logic blink_phase, blink_vis, lit;
    logic unused_wdata;

    assign unused_wdata = ^writedata[31:16];

    assign wr_en      = chipselect && !write_n;
    assign div_wr     = wr_en && (address == ADDR_DIV);
    assign enable     = ctrl_q[CTRL_EN];
    assign blink_en   = ctrl_q[CTRL_BLINK];
    assign active_low = ctrl_q[CTRL_ALOW];
    assign boundary   = (pwm_cnt_q == PWM_MAX);

    seg7_blink_timer #(.PRESCALE(PRESCALE)) u_blink (
        .clk          (clk),
        .reset        (reset),
        .enable_i     (enable),
        .blink_div_i  (div_q),
        .div_wr_i     (div_wr),
        .blink_phase_o(blink_phase)
    );

    assign blink_vis = !blink_en || blink_phase;
    assign lit       = enable && blink_vis && (pwm_cnt_q < bright_act_q);

    always_comb begin
        ctrl_d       = ctrl_q;
        bright_d     = bright_q;
        div_d        = div_q;
        seg_lat_d    = seg_lat_q;
        bright_act_d = bright_act_q;
        pwm_cnt_d    = 4'd0;
        if (wr_en) begin
            case (address)
                ADDR_CTRL:   ctrl_d   = writedata[2:0];
                ADDR_BRIGHT: bright_d = writedata[3:0];
                ADDR_DIV:    div_d    = writedata[15:0];
                default:     ;
            endcase
        end
        // Pattern and duty only change at the period boundary, so a period is never torn.
        if (boundary) begin
            seg_lat_d    = seg_in;
            bright_act_d = bright_q;
        end
        if (enable && !boundary) begin
            pwm_cnt_d = pwm_cnt_q + 4'd1;
        end
        hex_d = (seg_lat_q & {7{lit}}) ^ {7{active_low}};
    end

    always_comb begin
        readdata = 32'd0;
        case (address)
            ADDR_CTRL:   readdata = {29'd0, ctrl_q};
            ADDR_BRIGHT: readdata = {28'd0, bright_q};
            ADDR_DIV:    readdata = {16'd0, div_q};
            ADDR_STATUS: readdata = {23'd0, blink_phase, 1'b0, seg_lat_q};
            default:     readdata = 32'd0;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ctrl_q       <= CTRL_RST;
            bright_q     <= BRIGHT_RST;
            div_q        <= DIV_RST;
            pwm_cnt_q    <= 4'd0;
            seg_lat_q    <= SEG_RST;
            bright_act_q <= BRIGHT_RST;
            hex_q        <= HEX_RST;
        end else begin
            ctrl_q       <= ctrl_d;
            bright_q     <= bright_d;
            div_q        <= div_d;
            pwm_cnt_q    <= pwm_cnt_d;
            seg_lat_q    <= seg_lat_d;
            bright_act_q <= bright_act_d;
            hex_q        <= hex_d;
        end
    end

    assign hex_n = hex_q;

endmodule

// File: tb/tb_seg7_pwm_driver.sv
// Bench for seg7_pwm_driver: directed scenarios plus random bus/segment traffic,
// all compared cycle by cycle against an arithmetic model of the digit driver.
module tb_seg7_pwm_driver;

    localparam int P = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic [1:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [31:0] readdata;
    logic [6:0]  seg_in;
    logic [6:0]  hex_n;

    always #5 clk = ~clk;

    seg7_pwm_driver #(.PRESCALE(P)) dut (
        .clk       (clk),
        .reset     (reset),
        .address   (address),
        .chipselect(chipselect),
        .write_n   (write_n),
        .writedata (writedata),
        .readdata  (readdata),
        .seg_in    (seg_in),
        .hex_n     (hex_n)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Model state: registers, pwm position in period, prescaler, tick count, phase.
    int m_ctrl, m_bright, m_div, m_seg, m_ba, m_pwm, m_presc, m_bcnt, m_phase, m_hex;

    task automatic m_reset();
        m_ctrl = 5; m_bright = 15; m_div = 0; m_seg = 0; m_ba = 15;
        m_pwm = 0; m_presc = 0; m_bcnt = 0; m_phase = 1; m_hex = 127;
    endtask

    function automatic logic [31:0] m_read(input logic [1:0] a);
        case (a)
            2'd0:    m_read = 32'(m_ctrl);
            2'd1:    m_read = 32'(m_bright);
            2'd2:    m_read = 32'(m_div);
            default: m_read = 32'((m_phase << 8) | m_seg);
        endcase
    endfunction

    task automatic m_clock();
        int en, ben, alow, wr, lit, tick;
        en   = m_ctrl & 1;
        ben  = (m_ctrl >> 1) & 1;
        alow = (m_ctrl >> 2) & 1;
        wr   = (chipselect && !write_n) ? 1 : 0;
        lit  = (en != 0 && (ben == 0 || m_phase != 0) && m_pwm < m_ba) ? 1 : 0;
        m_hex = (lit != 0 ? m_seg : 0) ^ (alow != 0 ? 127 : 0);
        if (m_pwm == 14) begin
            m_seg = int'(seg_in);
            m_ba  = m_bright;
        end
        m_pwm = (en != 0) ? (m_pwm + 1) % 15 : 0;
        if (en == 0) begin
            m_presc = 0; m_bcnt = 0; m_phase = 1;
        end else begin
            tick    = (m_presc == P - 1) ? 1 : 0;
            m_presc = (m_presc + 1) % P;
            if ((wr != 0 && address == 2'd2) || m_div == 0) begin
                m_bcnt = 0; m_phase = 1;
            end else if (tick != 0) begin
                m_bcnt++;
                if (m_bcnt == m_div) begin
                    m_bcnt = 0;
                    m_phase = (m_phase != 0) ? 0 : 1;
                end
            end
        end
        if (wr != 0) begin
            case (address)
                2'd0: m_ctrl   = int'(writedata & 32'h7);
                2'd1: m_bright = int'(writedata & 32'hF);
                2'd2: m_div    = int'(writedata & 32'hFFFF);
                default: ;
            endcase
        end
    endtask

    task automatic tick_cycle();
        @(posedge clk);
        m_clock();
        #1;
        chk("hex_n", 32'(hex_n), 32'(m_hex));
        chk("readdata", readdata, m_read(address));
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick_cycle();
    endtask

    task automatic bus_wr(input logic [1:0] a, input logic [31:0] d);
        chipselect = 1'b1; write_n = 1'b0; address = a; writedata = d;
        tick_cycle();
        chipselect = 1'b0; write_n = 1'b1;
    endtask

    int cnt, last, prev, toggles, n;

    initial begin
        reset = 1'b1; address = 2'd0; chipselect = 1'b0; write_n = 1'b1;
        writedata = 32'd0; seg_in = 7'h3F;
        @(posedge clk); @(posedge clk); #1;
        chk("rst_hex", 32'(hex_n), 32'h7F);
        address = 2'd0; #1 chk("rst_ctrl", readdata, 32'h5);
        address = 2'd1; #1 chk("rst_bright", readdata, 32'hF);
        address = 2'd2; #1 chk("rst_div", readdata, 32'h0);
        address = 2'd3; #1 chk("rst_status", readdata, 32'h100);
        address = 2'd0;
        m_reset();
        @(negedge clk) reset = 1'b0;

        // Defaults: pattern appears one clock after the first boundary and stays.
        idle(16);
        for (int i = 0; i < 15; i++) begin
            chk("dflt_const", 32'(hex_n), 32'h40);
            tick_cycle();
        end

        // Duty 5/15.
        seg_in = 7'h06;
        bus_wr(2'd1, 32'd5);
        idle(16);
        cnt = 0;
        for (int i = 0; i < 15; i++) begin
            tick_cycle();
            if (hex_n == 7'h79) cnt++;
            else if (hex_n != 7'h7F) cnt += 100;
        end
        chk("duty5", 32'(cnt), 32'd5);

        bus_wr(2'd1, 32'd0);
        idle(16);
        cnt = 0;
        for (int i = 0; i < 15; i++) begin tick_cycle(); if (hex_n == 7'h7F) cnt++; end
        chk("duty0", 32'(cnt), 32'd15);

        bus_wr(2'd1, 32'd15);
        idle(16);
        cnt = 0;
        for (int i = 0; i < 15; i++) begin tick_cycle(); if (hex_n == 7'h79) cnt++; end
        chk("duty15", 32'(cnt), 32'd15);

        // Mid-period brightness change holds until the boundary.
        n = 0;
        while (m_pwm != 3 && n < 40) begin tick_cycle(); n++; end
        chk("wait_pwm3", 32'(m_pwm == 3), 32'd1);
        bus_wr(2'd1, 32'd0);
        idle(5);
        chk("midperiod_hold", 32'(hex_n), 32'h79);
        idle(16);
        chk("after_boundary_dark", 32'(hex_n), 32'h7F);

        // Blink: PRESCALE=4, BLINK_DIV=3 -> phase toggles every 12 clocks.
        bus_wr(2'd1, 32'd15);
        bus_wr(2'd0, 32'h7);
        bus_wr(2'd2, 32'd3);
        address = 2'd3;
        last = -1; prev = 1; toggles = 0;
        for (int i = 0; i < 80; i++) begin
            tick_cycle();
            if (int'(readdata[8]) != prev) begin
                if (last >= 0) chk("blink_period", 32'(i - last), 32'd12);
                last = i; prev = int'(readdata[8]); toggles++;
            end
        end
        chk("blink_toggles", 32'(toggles >= 5), 32'd1);
        n = 0;
        while (m_phase != 0 && n < 40) begin tick_cycle(); n++; end
        chk("wait_phase0", 32'(m_phase), 32'd0);
        bus_wr(2'd2, 32'd3);
        address = 2'd3; #1;
        chk("div_restart", 32'(readdata[8]), 32'd1);
        idle(10);

        // Polarity and disable.
        bus_wr(2'd2, 32'd0);
        bus_wr(2'd0, 32'h1);
        idle(17);
        chk("active_high", 32'(hex_n), 32'h06);
        bus_wr(2'd0, 32'h0);
        address = 2'd3;
        idle(3);
        chk("disabled", 32'(hex_n), 32'h00);
        chk("status_rd", readdata, 32'h106);
        bus_wr(2'd0, 32'h5);
        idle(20);

        // Random traffic.
        for (int i = 0; i < 600; i++) begin
            seg_in = 7'($urandom);
            if ($urandom_range(0, 3) == 0) begin
                address = 2'($urandom_range(0, 3));
                writedata = (address == 2'd2) ? 32'($urandom_range(0, 4)) : 32'($urandom);
                if (address == 2'd0 && $urandom_range(0, 3) != 0) writedata[0] = 1'b1;
                chipselect = 1'b1; write_n = 1'b0;
            end else begin
                address = 2'($urandom_range(0, 3));
                chipselect = 1'($urandom_range(0, 1)); write_n = 1'b1;
            end
            tick_cycle();
            chipselect = 1'b0; write_n = 1'b1;
        end

        // Reset mid-period with the phase low and the digit lit.
        bus_wr(2'd1, 32'd15);
        bus_wr(2'd0, 32'h5);
        bus_wr(2'd2, 32'd1);
        address = 2'd0;
        n = 0;
        while (!(m_pwm == 7 && m_phase == 0 && m_hex != 127) && n < 400) begin tick_cycle(); n++; end
        chk("wait_rst_point", 32'(m_pwm == 7 && m_phase == 0), 32'd1);
        #2 reset = 1'b1;
        #1 chk("rst_async_hex", 32'(hex_n), 32'h7F);
        m_reset();
        @(posedge clk);
        @(negedge clk) reset = 1'b0;
        address = 2'd0; #1 chk("rel_ctrl", readdata, 32'h5);
        address = 2'd1; #1 chk("rel_bright", readdata, 32'hF);
        address = 2'd2; #1 chk("rel_div", readdata, 32'h0);
        address = 2'd3; #1 chk("rel_status", readdata, 32'h100);
        idle(20);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
